lemming_world: RTL and testbench

LEMMING_WORLD -- requirements
Module: lemming_world

---
 rtl/lemming_world.sv | 200 ++++++++++++++++++++
 tb/tb_lemming_world.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lemming_world.sv
// -----------------------------------------------------------------------------
// lemming_world
//
// Purpose
//   One-dimensional world for a single lemming. The world holds the lemming's
//   position between a fixed left wall (0) and a right wall (RIGHT_WALL). An
//   optional obstacle can sit on any legal square. Each step_en cycle the
//   world either moves the lemming one square in its walking direction or,
//   when the next square is a wall or the obstacle, holds it in place and
//   raises the matching bump output. The external lemming FSM watches the
//   bump outputs to decide when to turn around.
//
// Parameters
//   POS_W       position width in bits
//   RIGHT_WALL  rightmost legal position (left wall is 0)
//   START_POS   position loaded on reset
//
// Ports
//   clk          in   1      single clock, rising edge
//   areset_n     in   1      asynchronous active-low reset
//   walk_left    in   1      lemming walking left
//   walk_right   in   1      lemming walking right
//   step_en      in   1      advance the world one step this cycle
//   obst_en      in   1      obstacle present
//   obst_pos     in   POS_W  obstacle position
//   bump_left    out  1      registered, lemming blocked on its left
//   bump_right   out  1      registered, lemming blocked on its right
//   pos          out  POS_W  registered lemming position
//   fault        out  1      sticky, walk_left and walk_right seen together
//   bump_cnt     out  8      (LEMMING_WORLD_STATS_EN only) count of cycles in
//                            which a bump output rises 0->1, saturating at 255
//
// Configuration
//   LEMMING_WORLD_STATS_EN  when defined, adds the bump_cnt port and counter.
//
// Handshake
//   No valid/ready handshake: walk_* and step_en are sampled every rising
//   edge; outputs change one cycle after the inputs that cause them.
// -----------------------------------------------------------------------------
module lemming_world #(
  parameter int POS_W      = 4,
  parameter int RIGHT_WALL = 9,
  parameter int START_POS  = 4
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             walk_left,
  input  logic             walk_right,
  input  logic             step_en,
  input  logic             obst_en,
  input  logic [POS_W-1:0] obst_pos,
  output logic             bump_left,
  output logic             bump_right,
  output logic [POS_W-1:0] pos,
  output logic             fault
`ifdef LEMMING_WORLD_STATS_EN
  ,
  output logic [7:0]       bump_cnt
`endif
);

  // Wall and start position at the widths they are compared against.
  localparam logic [POS_W:0]   RW_EXT    = (POS_W+1)'(RIGHT_WALL);
  localparam logic [POS_W-1:0] START_VAL = POS_W'(START_POS);
  localparam logic [POS_W-1:0] ONE       = POS_W'(1);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [POS_W-1:0] r_pos;
  logic             r_bump_l;
  logic             r_bump_r;
  logic             r_fault;

  // ---------------------------------------------------------------------------
  // Neighbour detection
  // ---------------------------------------------------------------------------
  // Neighbour squares are formed one bit wider than the position so that
  // pos-1 at pos==0 cannot alias onto a real square (and likewise pos+1 at the
  // top of the range).
  logic [POS_W:0] w_pos_ext;
  logic [POS_W:0] w_pos_m1;
  logic [POS_W:0] w_pos_p1;
  logic [POS_W:0] w_obst_ext;
  logic           w_obst_valid;
  logic           w_blocked_l;
  logic           w_blocked_r;

  assign w_pos_ext  = {1'b0, r_pos};
  assign w_pos_m1   = w_pos_ext - (POS_W+1)'(1);
  assign w_pos_p1   = w_pos_ext + (POS_W+1)'(1);
  assign w_obst_ext = {1'b0, obst_pos};

  // An obstacle on the lemming's own square or beyond the right wall is
  // meaningless and is ignored.
  assign w_obst_valid = obst_en
                     && (obst_pos != r_pos)
                     && (w_obst_ext <= RW_EXT);

  assign w_blocked_l = (r_pos == '0)
                    || (w_obst_valid && (w_obst_ext == w_pos_m1));

  // >= rather than == keeps the lemming pinned even if it were ever beyond
  // the wall.
  assign w_blocked_r = (w_pos_ext >= RW_EXT)
                    || (w_obst_valid && (w_obst_ext == w_pos_p1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic [POS_W-1:0] w_pos_nxt;
  logic             w_bump_l_nxt;
  logic             w_bump_r_nxt;
  logic             w_fault_nxt;
  logic             w_bump_rise;

  always_comb begin
    w_pos_nxt    = r_pos;
    w_bump_l_nxt = r_bump_l;
    w_bump_r_nxt = r_bump_r;
    // Contradictory walk inputs are a lemming-FSM bug; latch it regardless
    // of step_en so a glitch between steps is still caught.
    w_fault_nxt  = r_fault | (walk_left & walk_right);

    if (step_en) begin
      // Each step recomputes both bumps, so they behave as levels that stay
      // high for as long as the lemming keeps walking into the blocker, and
      // the opposite bump always clears.
      w_bump_l_nxt = 1'b0;
      w_bump_r_nxt = 1'b0;
      unique case ({walk_left, walk_right})
        2'b10: begin
          if (w_blocked_l) begin
            w_bump_l_nxt = 1'b1;
          end else begin
            w_pos_nxt = r_pos - ONE;
          end
        end
        2'b01: begin
          if (w_blocked_r) begin
            w_bump_r_nxt = 1'b1;
          end else begin
            w_pos_nxt = r_pos + ONE;
          end
        end
        default: begin
          // Idle or both directions: stand still with no bump.
          w_pos_nxt = r_pos;
        end
      endcase
    end
  end

  // A bump edge is counted once per cycle even if it came from either side.
  assign w_bump_rise = (w_bump_l_nxt & ~r_bump_l) | (w_bump_r_nxt & ~r_bump_r);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_pos    <= START_VAL;
      r_bump_l <= 1'b0;
      r_bump_r <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_pos    <= w_pos_nxt;
      r_bump_l <= w_bump_l_nxt;
      r_bump_r <= w_bump_r_nxt;
      r_fault  <= w_fault_nxt;
    end
  end

`ifdef LEMMING_WORLD_STATS_EN
  logic [7:0] r_bump_cnt;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_bump_cnt <= 8'd0;
    end else if (w_bump_rise && (r_bump_cnt != 8'hFF)) begin
      r_bump_cnt <= r_bump_cnt + 8'd1;
    end
  end

  assign bump_cnt = r_bump_cnt;
`else
  // Edge detection exists only to feed the statistics counter.
  logic w_unused_rise;
  assign w_unused_rise = w_bump_rise;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pos        = r_pos;
  assign bump_left  = r_bump_l;
  assign bump_right = r_bump_r;
  assign fault      = r_fault;

endmodule

// File: tb/tb_lemming_world.sv
// -----------------------------------------------------------------------------
// tb_lemming_world
//
// Bench for lemming_world with default parameters (POS_W=4, RIGHT_WALL=9,
// START_POS=4). A vector table walks the lemming through walls, obstacles,
// idle and hold cycles and a fault; hand-written sequences cover the
// asynchronous reset pulse and a closed loop with a lemming FSM that turns
// around on each bump. Expected outputs go into exp_q when a step is driven
// and are popped when the DUT has registered the result.
// -----------------------------------------------------------------------------
module tb_lemming_world;

  logic       clk;
  logic       areset_n;
  logic       walk_left;
  logic       walk_right;
  logic       step_en;
  logic       obst_en;
  logic [3:0] obst_pos;
  logic       bump_left;
  logic       bump_right;
  logic [3:0] pos;
  logic       fault;
`ifdef LEMMING_WORLD_STATS_EN
  logic [7:0] bump_cnt;
`endif

  lemming_world #(.POS_W(4), .RIGHT_WALL(9), .START_POS(4)) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .walk_left  (walk_left),
    .walk_right (walk_right),
    .step_en    (step_en),
    .obst_en    (obst_en),
    .obst_pos   (obst_pos),
    .bump_left  (bump_left),
    .bump_right (bump_right),
    .pos        (pos),
    .fault      (fault)
`ifdef LEMMING_WORLD_STATS_EN
    ,
    .bump_cnt   (bump_cnt)
`endif
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  // Packed expectation: {fault, bump_left, bump_right, pos}
  logic [6:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  // Independent bump-edge counter model, fed from the expected bump values.
  int         m_cnt     = 0;
  logic       m_prev_bl = 1'b0;
  logic       m_prev_br = 1'b0;

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt     = 0;
    m_prev_bl = 1'b0;
    m_prev_br = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one step, inputs driven on the falling edge, result sampled 1ns
  // after the following rising edge.
  // ---------------------------------------------------------------------------
  task automatic step_dut(input logic wl, input logic wr, input logic se,
                          input logic oe, input logic [3:0] op,
                          input logic [6:0] exp, input string nm);
    logic [6:0] e;
    logic [6:0] got;
    @(negedge clk);
    walk_left  = wl;
    walk_right = wr;
    step_en    = se;
    obst_en    = oe;
    obst_pos   = op;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    got = {fault, bump_left, bump_right, pos};
    check(nm, {1'b0, got}, {1'b0, e});
    check({nm, "_excl"}, {7'd0, bump_left & bump_right}, 8'd0);
    if ((e[5] && !m_prev_bl) || (e[4] && !m_prev_br)) begin
      if (m_cnt < 255) m_cnt++;
    end
    m_prev_bl = e[5];
    m_prev_br = e[4];
`ifdef LEMMING_WORLD_STATS_EN
    check({nm, "_cnt"}, bump_cnt, 8'(m_cnt));
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       wl;
    logic       wr;
    logic       se;
    logic       oe;
    logic [3:0] op;
    logic [3:0] e_pos;
    logic       e_bl;
    logic       e_br;
    logic       e_f;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic wl, input logic wr, input logic se,
                              input logic oe, input int op, input int e_pos,
                              input logic e_bl, input logic e_br, input logic e_f);
    vec_t v;
    v.wl = wl; v.wr = wr; v.se = se; v.oe = oe; v.op = 4'(op);
    v.e_pos = 4'(e_pos); v.e_bl = e_bl; v.e_br = e_br; v.e_f = e_f;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int   m_pos;
    logic m_bl;
    logic m_br;
    logic dir_right;
    logic [6:0] e;

    areset_n   = 1'b0;
    walk_left  = 1'b0;
    walk_right = 1'b0;
    step_en    = 1'b0;
    obst_en    = 1'b0;
    obst_pos   = 4'd0;

    // Table: wl wr se oe op | pos bl br fault
    // Walk left from START_POS into the left wall.
    vq.push_back(mk(1,0,1,0,0, 3,0,0,0));
    vq.push_back(mk(1,0,1,0,0, 2,0,0,0));
    vq.push_back(mk(1,0,1,0,0, 1,0,0,0));
    vq.push_back(mk(1,0,1,0,0, 0,0,0,0));
    vq.push_back(mk(1,0,1,0,0, 0,1,0,0));
    vq.push_back(mk(1,0,1,0,0, 0,1,0,0));
    // Turn and walk right up to the right wall.
    for (int p = 1; p <= 9; p++) vq.push_back(mk(0,1,1,0,0, p,0,0,0));
    vq.push_back(mk(0,1,1,0,0, 9,0,1,0));
    vq.push_back(mk(0,1,1,0,0, 9,0,1,0));
    // step_en=0 holds everything, bump included.
    vq.push_back(mk(0,1,0,0,0, 9,0,1,0));
    // Turning left drops bump_right one cycle later.
    vq.push_back(mk(1,0,1,0,0, 8,0,0,0));
    vq.push_back(mk(1,0,1,0,0, 7,0,0,0));
    vq.push_back(mk(1,0,1,0,0, 6,0,0,0));
    vq.push_back(mk(1,0,1,0,0, 5,0,0,0));
    // Obstacle at 6 blocks rightward motion from 5; removing it frees it.
    vq.push_back(mk(0,1,1,1,6, 5,0,1,0));
    vq.push_back(mk(0,1,1,1,6, 5,0,1,0));
    vq.push_back(mk(0,1,1,0,6, 6,0,0,0));
    // Obstacle on the lemming's own square is ignored.
    vq.push_back(mk(0,1,1,1,6, 7,0,0,0));
    // Obstacle behind (at 6) blocks a left walk from 7.
    vq.push_back(mk(1,0,1,1,6, 7,1,0,0));
    // Idle with step_en clears the bump; step_en=0 then holds.
    vq.push_back(mk(0,0,1,1,6, 7,0,0,0));
    vq.push_back(mk(1,0,0,1,6, 7,0,0,0));
    // Obstacle beyond the right wall is ignored.
    vq.push_back(mk(0,1,1,1,15, 8,0,0,0));
    vq.push_back(mk(0,1,1,1,15, 9,0,0,0));
    vq.push_back(mk(0,1,1,1,10, 9,0,1,0));
    // Both directions: hold, clear bumps, raise sticky fault.
    vq.push_back(mk(1,1,1,0,0, 9,0,0,1));
    vq.push_back(mk(1,0,1,0,0, 8,0,0,1));
    vq.push_back(mk(1,0,1,0,0, 7,0,0,1));
    // Obstacle ahead at 8 gives a bump to clear by reset below.
    vq.push_back(mk(0,1,1,1,8, 7,0,1,1));

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_pos",   {4'd0, pos},        8'd4);
    check("rst_bumps", {6'd0, bump_left, bump_right}, 8'd0);
    check("rst_fault", {7'd0, fault},      8'd0);
`ifdef LEMMING_WORLD_STATS_EN
    check("rst_cnt",   bump_cnt,           8'd0);
`endif
    @(negedge clk);
    areset_n = 1'b1;
    model_reset();

    foreach (vq[i]) begin
      e = {vq[i].e_f, vq[i].e_bl, vq[i].e_br, vq[i].e_pos};
      step_dut(vq[i].wl, vq[i].wr, vq[i].se, vq[i].oe, vq[i].op, e,
               $sformatf("vec%0d", i));
    end

    // Asynchronous reset pulse between edges at pos=7 with a bump pending.
    @(negedge clk);
    step_en = 1'b0;
    #2 areset_n = 1'b0;
    #1;
    check("arst_pos",   {4'd0, pos}, 8'd4);
    check("arst_bumps", {6'd0, bump_left, bump_right}, 8'd0);
    check("arst_fault", {7'd0, fault}, 8'd0);
`ifdef LEMMING_WORLD_STATS_EN
    check("arst_cnt",   bump_cnt, 8'd0);
`endif
    #1 areset_n = 1'b1;
    model_reset();

    // First edge after release resumes stepping.
    step_dut(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 7'b000_0101, "resume");

    // Closed loop: lemming walks left first and turns on every bump.
    m_pos     = 5;
    m_bl      = 1'b0;
    m_br      = 1'b0;
    dir_right = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!dir_right) begin
        m_br = 1'b0;
        if (m_pos == 0) m_bl = 1'b1;
        else begin m_pos--; m_bl = 1'b0; end
      end else begin
        m_bl = 1'b0;
        if (m_pos == 9) m_br = 1'b1;
        else begin m_pos++; m_br = 1'b0; end
      end
      step_dut(!dir_right, dir_right, 1'b1, 1'b0, 4'd0,
               {1'b0, m_bl, m_br, 4'(m_pos)}, $sformatf("loop%0d", k));
      if (!dir_right && m_bl) dir_right = 1'b1;
      else if (dir_right && m_br) dir_right = 1'b0;
    end

`ifdef LEMMING_WORLD_STATS_EN
    // Two wall hits at minimum must have been counted by now.
    check("loop_cnt_ge2", {7'd0, (bump_cnt >= 8'd2)}, 8'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
